// File: rtl/fpga_puf_axi_read_master.sv
// -----------------------------------------------------------------------------
// fpga_puf_axi_read_master
//
// AXI4 read master that fetches a block of challenge words from host memory
// and replays them as an AXI4-Stream towards the PUF core.
//
// Transfer flow:
//   - ctrl_start (honoured in IDLE only) latches the start address and byte
//     count. The beat count is the byte count rounded up to whole data beats.
//   - Read bursts of up to C_BURST_LEN beats are issued. A burst is only
//     requested when the data FIFO is guaranteed to have room for all of its
//     beats, so m_axi_rready can stay high for the whole transfer.
//   - Returned beats pass through a FIFO with a registered output stage and
//     leave on m_axis_*. tlast marks the final beat of the transfer.
//   - ctrl_done pulses for one cycle after the last stream beat is accepted.
//     A zero-byte request goes straight to DONE without any bus activity.
//
// Ports:
//   clk_i, rstn_i             clock, asynchronous active-low reset
//   ctrl_start / ctrl_done    start pulse in, completion pulse out
//   ctrl_addr_offset          start byte address (burst aligned)
//   ctrl_xfer_size_in_bytes   number of bytes to read
//   err_o                     sticky rlast protocol error
//   m_axi_ar*                 read address channel (master side)
//   m_axi_r*                  read data channel (master side)
//   m_axis_t*                 output stream
//
// Optional feature (compile-time macro FPGA_PUF_RD_RLAST_CHK_EN):
//   when defined, every R beat's rlast is compared with the expected
//   end-of-burst position and a mismatch sets err_o until reset. When the
//   macro is undefined, rlast is ignored and err_o is tied low.
// -----------------------------------------------------------------------------
module fpga_puf_axi_read_master #(
    parameter int C_M_AXI_ADDR_WIDTH = 64,
    parameter int C_M_AXI_DATA_WIDTH = 512,
    parameter int C_XFER_SIZE_WIDTH  = 32,
    parameter int C_BURST_LEN        = 8,
    parameter int C_FIFO_DEPTH       = 32
) (
    input  logic                          clk_i,
    input  logic                          rstn_i,
    input  logic                          ctrl_start,
    output logic                          ctrl_done,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0] ctrl_addr_offset,
    input  logic [C_XFER_SIZE_WIDTH-1:0]  ctrl_xfer_size_in_bytes,
    output logic                          err_o,
    output logic                          m_axi_arvalid,
    input  logic                          m_axi_arready,
    output logic [C_M_AXI_ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [7:0]                    m_axi_arlen,
    input  logic                          m_axi_rvalid,
    output logic                          m_axi_rready,
    input  logic [C_M_AXI_DATA_WIDTH-1:0] m_axi_rdata,
    input  logic                          m_axi_rlast,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic [C_M_AXI_DATA_WIDTH-1:0] m_axis_tdata,
    output logic                          m_axis_tlast
);

    localparam int DW_BYTES = C_M_AXI_DATA_WIDTH / 8;
    localparam int DWB_LOG  = $clog2(DW_BYTES);
    localparam int BW       = C_XFER_SIZE_WIDTH + 1;        // beat counter width
    localparam int BLW      = $clog2(C_BURST_LEN) + 1;      // burst beat count width
    localparam int PW       = $clog2(C_FIFO_DEPTH);         // FIFO pointer width
    localparam int CW       = PW + 1;                       // FIFO occupancy width
    localparam logic [C_M_AXI_ADDR_WIDTH-1:0] BURST_BYTES =
        C_M_AXI_ADDR_WIDTH'(C_BURST_LEN * DW_BYTES);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t state_reg, state_next;

    // Transfer bookkeeping
    logic [BW-1:0]                 total_reg;      // beats in this transfer
    logic [BW-1:0]                 ar_rem_reg;     // beats not yet requested
    logic [BW-1:0]                 load_idx_reg;   // beats moved into the output stage
    logic [CW-1:0]                 reserved_reg;   // requested beats not yet received
    logic                          arvalid_reg;
    logic [C_M_AXI_ADDR_WIDTH-1:0] araddr_reg;
    logic [7:0]                    arlen_reg;

    // FIFO storage plus one registered output stage
    logic [C_M_AXI_DATA_WIDTH-1:0] mem [C_FIFO_DEPTH];
    logic [PW-1:0]                 wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0]                 mem_count_reg;
    logic                          tvalid_reg, tlast_reg;
    logic [C_M_AXI_DATA_WIDTH-1:0] tdata_reg;

    // Combinational helpers
    logic [BW-1:0]  start_total;
    logic [BLW-1:0] start_burst, burst_beats;
    logic           start_go, ar_hs, r_hs, t_hs, rready;
    logic [CW-1:0]  fifo_count, reserved_next;
    logic [CW:0]    free_space;
    logic           credit_ok, ar_issue;
    logic           load, load_mem, load_byp, mem_wr, load_is_last;

    // Round the byte count up to whole beats; one extra bit so a size near
    // the top of the range cannot overflow the rounding add.
    assign start_total = ({1'b0, ctrl_xfer_size_in_bytes} + BW'(DW_BYTES - 1)) >> DWB_LOG;
    assign start_burst = (start_total >= BW'(C_BURST_LEN)) ? BLW'(C_BURST_LEN)
                                                          : start_total[BLW-1:0];
    assign burst_beats = (ar_rem_reg >= BW'(C_BURST_LEN)) ? BLW'(C_BURST_LEN)
                                                         : ar_rem_reg[BLW-1:0];

    assign start_go = (state_reg == ST_IDLE) && ctrl_start;
    assign ar_hs    = arvalid_reg && m_axi_arready;
    assign r_hs     = m_axi_rvalid && rready;
    assign t_hs     = tvalid_reg && m_axis_tready;

    // Beats already buffered plus beats promised by outstanding bursts must
    // leave room for the whole next burst before it may be requested.
    assign fifo_count = mem_count_reg + CW'(tvalid_reg);
    assign free_space = (CW+1)'(C_FIFO_DEPTH) - {1'b0, fifo_count} - {1'b0, reserved_reg};
    assign credit_ok  = free_space >= (CW+1)'(burst_beats);
    assign ar_issue   = (state_reg == ST_RUN) && !arvalid_reg && (ar_rem_reg != '0) && credit_ok;

    assign reserved_next = reserved_reg
                         + (ar_hs ? (CW'(arlen_reg) + CW'(1)) : CW'(0))
                         - (r_hs ? CW'(1) : CW'(0));

    // The output stage refills whenever it is empty or being consumed. With
    // nothing stored, an arriving beat bypasses the array straight into it.
    assign load         = !tvalid_reg || t_hs;
    assign load_mem     = load && (mem_count_reg != '0);
    assign load_byp     = load && (mem_count_reg == '0) && r_hs;
    assign mem_wr       = r_hs && !load_byp;
    assign load_is_last = (load_idx_reg == (total_reg - BW'(1)));

    // Next-state and control outputs
    always_comb begin
        state_next = state_reg;
        rready     = 1'b0;
        ctrl_done  = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (ctrl_start) begin
                    state_next = (start_total == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                rready = 1'b1;
                if (t_hs && tlast_reg) begin
                    state_next = ST_DONE;
                end else if ((ar_rem_reg == '0) && !arvalid_reg) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                rready = 1'b1;
                if (t_hs && tlast_reg) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                ctrl_done  = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Address channel and transfer counters
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            total_reg    <= '0;
            ar_rem_reg   <= '0;
            reserved_reg <= '0;
            arvalid_reg  <= 1'b0;
            araddr_reg   <= '0;
            arlen_reg    <= '0;
        end else begin
            reserved_reg <= reserved_next;
            if (start_go) begin
                // The FIFO is empty here, so the first burst always fits.
                total_reg   <= start_total;
                ar_rem_reg  <= start_total;
                arvalid_reg <= (start_total != '0);
                araddr_reg  <= ctrl_addr_offset;
                if (start_total != '0) begin
                    arlen_reg <= 8'(start_burst - BLW'(1));
                end
            end else if (ar_hs) begin
                arvalid_reg <= 1'b0;
                araddr_reg  <= araddr_reg + BURST_BYTES;
                ar_rem_reg  <= ar_rem_reg - (BW'(arlen_reg) + BW'(1));
            end else if (ar_issue) begin
                arvalid_reg <= 1'b1;
                arlen_reg   <= 8'(burst_beats - BLW'(1));
            end
        end
    end

    // FIFO storage array (no reset, written only)
    always_ff @(posedge clk_i) begin
        if (mem_wr) begin
            mem[wr_ptr_reg] <= m_axi_rdata;
        end
    end

    // FIFO pointers and registered output stage
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            mem_count_reg <= '0;
            tvalid_reg    <= 1'b0;
            tlast_reg     <= 1'b0;
            tdata_reg     <= '0;
            load_idx_reg  <= '0;
        end else begin
            if (mem_wr) begin
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            end
            if (load_mem) begin
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
            end
            mem_count_reg <= mem_count_reg + CW'(mem_wr) - CW'(load_mem);

            if (start_go) begin
                load_idx_reg <= '0;
            end else if (load) begin
                if (load_mem || load_byp) begin
                    tvalid_reg   <= 1'b1;
                    tdata_reg    <= load_mem ? mem[rd_ptr_reg] : m_axi_rdata;
                    tlast_reg    <= load_is_last;
                    load_idx_reg <= load_idx_reg + BW'(1);
                end else begin
                    tvalid_reg <= 1'b0;
                    tlast_reg  <= 1'b0;
                end
            end
        end
    end

`ifdef FPGA_PUF_RD_RLAST_CHK_EN
    // Every burst is C_BURST_LEN beats except possibly the final one, so the
    // expected rlast position follows from the beat position alone.
    logic [BW-1:0]  r_idx_reg;
    logic [BLW-1:0] r_pos_reg;
    logic           err_reg;
    logic           rlast_exp;

    assign rlast_exp = (r_pos_reg == BLW'(C_BURST_LEN - 1)) ||
                       (r_idx_reg == (total_reg - BW'(1)));

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_idx_reg <= '0;
            r_pos_reg <= '0;
            err_reg   <= 1'b0;
        end else if (start_go) begin
            r_idx_reg <= '0;
            r_pos_reg <= '0;
        end else if (r_hs) begin
            if (m_axi_rlast != rlast_exp) begin
                err_reg <= 1'b1;
            end
            r_idx_reg <= r_idx_reg + BW'(1);
            r_pos_reg <= rlast_exp ? '0 : (r_pos_reg + BLW'(1));
        end
    end

    assign err_o = err_reg;
`else
    logic unused_rlast;
    assign unused_rlast = m_axi_rlast;
    assign err_o        = 1'b0;
`endif

    assign m_axi_arvalid = arvalid_reg;
    assign m_axi_araddr  = araddr_reg;
    assign m_axi_arlen   = arlen_reg;
    assign m_axi_rready  = rready;
    assign m_axis_tvalid = tvalid_reg;
    assign m_axis_tdata  = tdata_reg;
    assign m_axis_tlast  = tlast_reg;

endmodule
